// File: rtl/sqrt2_host_pkg.sv
// Shared state encoding, result record and FP16 constants for the sqrt2 bus initiator.
package sqrt2_host_pkg;

  localparam int unsigned FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
  localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StWait,
    StGap
  } state_t;

  typedef struct packed {
    logic [FP16_W-1:0] data;
    logic              is_nan;
    logic              is_pinf;
    logic              is_ninf;
  } result_t;

endpackage

// File: rtl/sqrt2_io_driver.sv
// Tri-state buffer for the shared operand/result bus: registered enable and data,
// with the resolved bus value returned for capture.
module sqrt2_io_driver
  import sqrt2_host_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              drive_i,
  input  logic [FP16_W-1:0] data_i,
  inout  wire  [FP16_W-1:0] bus_io,
  output logic [FP16_W-1:0] rd_data_o
);

  logic              drive_q;
  logic [FP16_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (drive_i) data_d = data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drive_q <= 1'b0;
      data_q  <= '0;
    end else begin
      drive_q <= drive_i;
      data_q  <= data_d;
    end
  end

  assign bus_io    = drive_q ? data_q : {FP16_W{1'bz}};
  assign rd_data_o = bus_io;

endmodule

// File: rtl/sqrt2_host.sv
// Bus-side initiator for one sqrt2 unit: operand stream in, result stream out.
// Optional WAIT watchdog enabled by defining SQRT2_HOST_TIMEOUT_EN.
module sqrt2_host
  import sqrt2_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [FP16_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [FP16_W-1:0] OUT_DATA,
  output logic              OUT_IS_NAN,
  output logic              OUT_IS_PINF,
  output logic              OUT_IS_NINF,
  output logic              OUT_TIMEOUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  inout  wire  [FP16_W-1:0] IO_DATA,
  output logic              ENABLE,
  input  logic              RESULT,
  input  logic              IS_NAN,
  input  logic              IS_PINF,
  input  logic              IS_NINF
);

  state_t            state_q, state_d;
  result_t           res_q, res_d;
  logic              out_valid_q, out_valid_d;
  logic              enable_q, enable_d;
  logic              drive_d;
  logic              timeout_hit;
  logic [FP16_W-1:0] bus_rd;

  assign IN_READY = (state_q == StIdle) && (!out_valid_q || OUT_READY);

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && OUT_READY) out_valid_d = 1'b0;
    unique case (state_q)
      StIdle:  if (IN_VALID && IN_READY) state_d = StDrive;
      StDrive: state_d = StWait;
      StWait: begin
        if (RESULT) begin
          res_d       = '{data: bus_rd, is_nan: IS_NAN, is_pinf: IS_PINF, is_ninf: IS_NINF};
          out_valid_d = 1'b1;
          state_d     = StGap;
        end else if (timeout_hit) begin
          res_d       = '{data: FP16_QNAN, is_nan: 1'b1, is_pinf: 1'b0, is_ninf: 1'b0};
          out_valid_d = 1'b1;
          state_d     = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus drive and ENABLE follow the next state so both leave a flop, never a gate.
  assign drive_d  = (state_d == StDrive);
  assign enable_d = (state_d == StDrive) || (state_d == StWait);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      enable_q    <= enable_d;
    end
  end

`ifdef SQRT2_HOST_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    timeout_hit = 1'b0;
    if (state_q == StDrive) begin
      cnt_d = '0;
    end else if (state_q == StWait) begin
      cnt_d       = cnt_q + CntW'(1);
      timeout_hit = !RESULT && (cnt_d == CntW'(TIMEOUT_CYCLES));
      if (RESULT) timeout_d = 1'b0;
      else if (timeout_hit) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign OUT_TIMEOUT = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign OUT_TIMEOUT = 1'b0;
`endif

  sqrt2_io_driver u_io_driver (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .drive_i  (drive_d),
    .data_i   (IN_DATA),
    .bus_io   (IO_DATA),
    .rd_data_o(bus_rd)
  );

  assign OUT_DATA    = res_q.data;
  assign OUT_IS_NAN  = res_q.is_nan;
  assign OUT_IS_PINF = res_q.is_pinf;
  assign OUT_IS_NINF = res_q.is_ninf;
  assign OUT_VALID   = out_valid_q;
  assign ENABLE      = enable_q;

endmodule

// File: tb/tb_sqrt2_host.sv
// Self-checking bench for sqrt2_host with a behavioural sqrt2 responder on the shared bus.
module tb_sqrt2_host;
  import sqrt2_host_pkg::*;

  localparam int unsigned TO = 32;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] IN_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] OUT_DATA;
  logic        OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF, OUT_TIMEOUT, OUT_VALID;
  logic        OUT_READY;
  wire  [15:0] io_data;
  logic        ENABLE;
  logic        RESULT, IS_NAN, IS_PINF, IS_NINF;

  logic        r_drive;
  logic [15:0] r_data;
  int          checks = 0;
  int          failures = 0;
  int          resp_lat = 1;
  bit          resp_stub = 1'b0;
  bit          resp_early = 1'b0;
  logic [15:0] last_op;
  logic [15:0] pick [4] = '{16'h4400, 16'h3C00, 16'h7C00, 16'hBC00};

  always #5 CLK = ~CLK;

  // Released bus reads as all ones.
  assign io_data = r_drive ? r_data : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pu_b (io_data[g]);
  end

  sqrt2_host #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OUT_DATA(OUT_DATA), .OUT_IS_NAN(OUT_IS_NAN), .OUT_IS_PINF(OUT_IS_PINF),
    .OUT_IS_NINF(OUT_IS_NINF), .OUT_TIMEOUT(OUT_TIMEOUT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .IO_DATA(io_data), .ENABLE(ENABLE), .RESULT(RESULT),
    .IS_NAN(IS_NAN), .IS_PINF(IS_PINF), .IS_NINF(IS_NINF)
  );

  // Responder answer {ninf, pinf, nan, data}: true roots for named operands, else a
  // scrambled stand-in so every data and flag bit gets carried across.
  function automatic logic [18:0] model(input logic [15:0] a);
    case (a)
      16'h4400: return {3'b000, 16'h4000};
      16'h3C00: return {3'b000, 16'h3C00};
      16'h7C00: return {3'b010, FP16_PINF};
      16'hBC00: return {3'b001, FP16_QNAN};
      default:  return {a[2:0], a ^ 16'h5A5A};
    endcase
  endfunction

  initial begin
    logic        en_prev;
    int          cnt;
    logic [18:0] rsp;
    en_prev = 1'b0; cnt = 0; r_drive = 1'b0; r_data = '0; last_op = '0;
    RESULT = 1'b0; IS_NAN = 1'b0; IS_PINF = 1'b0; IS_NINF = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        en_prev = 1'b0; r_drive = 1'b0; RESULT = 1'b0;
        {IS_NINF, IS_PINF, IS_NAN} = 3'b000;
      end else begin
        if (ENABLE && !en_prev) begin
          last_op = io_data;
          cnt     = resp_lat;
          RESULT  = resp_early;
        end else if (ENABLE && !resp_stub) begin
          if (cnt == 0) begin
            rsp     = model(last_op);
            r_data  = rsp[15:0];
            r_drive = 1'b1;
            {IS_NINF, IS_PINF, IS_NAN} = rsp[18:16];
            RESULT  = 1'b1;
          end else begin
            cnt--;
            RESULT = 1'b0;
          end
        end else begin
          r_drive = 1'b0; RESULT = 1'b0;
          {IS_NINF, IS_PINF, IS_NAN} = 3'b000;
        end
        en_prev = ENABLE;
      end
    end
  end

  task automatic send(input logic [15:0] d, output bit ok);
    IN_DATA = d; IN_VALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge CLK); ok = IN_READY;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge CLK); #1;
      if (OUT_VALID) begin k = i; break; end
    end
  endtask

  task automatic test_reset;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", OUT_VALID); end
    checks++; if (OUT_DATA !== 16'h0) begin failures++; $display("FAIL rst_data: got %h want 0000", OUT_DATA); end
    checks++; if ({OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF, OUT_TIMEOUT} !== 4'b0) begin
      failures++; $display("FAIL rst_flags: got %b want 0000", {OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF, OUT_TIMEOUT});
    end
    checks++; if (ENABLE !== 1'b0 || io_data !== 16'hFFFF) begin
      failures++; $display("FAIL rst_bus: got en=%b bus=%h want en=0 bus=ffff", ENABLE, io_data);
    end
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", IN_READY); end
  endtask

  task automatic test_basic;
    bit ok; int k;
    resp_lat = 2; resp_early = 1'b1; OUT_READY = 1'b1;
    send(16'h4400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_accept: got 0 want 1"); end
    checks++; if (ENABLE !== 1'b1 || io_data !== 16'h4400) begin
      failures++; $display("FAIL basic_drive: got en=%b bus=%h want en=1 bus=4400", ENABLE, io_data);
    end
    @(posedge CLK); #1;
    checks++; if (ENABLE !== 1'b1 || io_data !== 16'hFFFF || OUT_VALID !== 1'b0) begin
      failures++; $display("FAIL basic_wait: got en=%b bus=%h v=%b want 1 ffff 0", ENABLE, io_data, OUT_VALID);
    end
    wait_valid(20, k);
    checks++; if (k + 1 != 2 + resp_lat) begin failures++; $display("FAIL basic_latency: got %0d want %0d", k + 1, 2 + resp_lat); end
    checks++; if ({OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA} !== model(16'h4400) || ENABLE !== 1'b0) begin
      failures++; $display("FAIL basic_result: got %h en=%b want %h en=0", {OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA}, ENABLE, model(16'h4400));
    end
    resp_early = 1'b0; IN_DATA = 16'h3C00; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    checks++; if (ENABLE !== 1'b0 || OUT_VALID !== 1'b0) begin
      failures++; $display("FAIL basic_gap: got en=%b v=%b want 0 0", ENABLE, OUT_VALID);
    end
    @(posedge CLK); #1; IN_VALID = 1'b0;
    checks++; if (ENABLE !== 1'b1 || io_data !== 16'h3C00) begin
      failures++; $display("FAIL basic_next_drive: got en=%b bus=%h want 1 3c00", ENABLE, io_data);
    end
    wait_valid(20, k);
    checks++; if (OUT_DATA !== 16'h3C00) begin failures++; $display("FAIL basic_second: got %h want 3c00", OUT_DATA); end
    @(posedge CLK); #1;
  endtask

  task automatic test_specials;
    bit ok; int k;
    logic [15:0] ops [2] = '{16'h7C00, 16'hBC00};
    resp_lat = 0; OUT_READY = 1'b1;
    foreach (ops[i]) begin
      send(ops[i], ok);
      wait_valid(20, k);
      checks++; if ({OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA} !== model(ops[i])) begin
        failures++; $display("FAIL special_%h: got %h want %h", ops[i], {OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA}, model(ops[i]));
      end
      checks++; if (last_op !== ops[i]) begin failures++; $display("FAIL special_op: got %h want %h", last_op, ops[i]); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int k;
    OUT_READY = 1'b0; resp_lat = 1; resp_early = 1'b0;
    IN_DATA = 16'h3C00; IN_VALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK); ok = IN_READY;
      @(posedge CLK); #1;
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_accept: got 0 want 1"); end
    IN_DATA = 16'h4400;
    wait_valid(20, k);
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 16'h3C00) begin
      failures++; $display("FAIL b2b_hold: got v=%b d=%h want 1 3c00", OUT_VALID, OUT_DATA);
    end
    checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL b2b_stall: got %b want 0", IN_READY); end
    OUT_READY = 1'b1;
    @(negedge CLK);
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b want 1", IN_READY); end
    @(posedge CLK); #1; IN_VALID = 1'b0;
    checks++; if (ENABLE !== 1'b1 || io_data !== 16'h4400 || OUT_VALID !== 1'b0) begin
      failures++; $display("FAIL b2b_swap: got en=%b bus=%h v=%b want 1 4400 0", ENABLE, io_data, OUT_VALID);
    end
    wait_valid(20, k);
    checks++; if (OUT_DATA !== 16'h4000) begin failures++; $display("FAIL b2b_second: got %h want 4000", OUT_DATA); end
    @(posedge CLK); #1;
  endtask

  task automatic test_random;
    bit ok; int k; logic [15:0] op; logic [18:0] exp;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      resp_lat = $urandom_range(0, 5);
      resp_early = 1'($urandom_range(0, 1));
      exp = model(op);
      OUT_READY = 1'b0;
      send(op, ok);
      wait_valid(20, k);
      checks++; if (!ok || k != 2 + resp_lat) begin
        failures++; $display("FAIL rand_latency: got ok=%b k=%0d want k=%0d", ok, k, 2 + resp_lat);
      end
      checks++; if ({OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA} !== exp) begin
        failures++; $display("FAIL rand_result op=%h: got %h want %h", op, {OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA}, exp);
      end
      checks++; if (last_op !== op) begin failures++; $display("FAIL rand_operand: got %h want %h", last_op, op); end
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      checks++; if (OUT_VALID !== 1'b1 || {OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA} !== exp) begin
        failures++; $display("FAIL rand_hold: got v=%b %h want 1 %h", OUT_VALID, {OUT_IS_NINF, OUT_IS_PINF, OUT_IS_NAN, OUT_DATA}, exp);
      end
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;
      checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rand_consume: got %b want 0", OUT_VALID); end
    end
  endtask

  task automatic test_timeout;
    bit ok; int k;
    resp_stub = 1'b1; resp_early = 1'b0; OUT_READY = 1'b0;
    send(16'h3C00, ok);
    wait_valid(100, k);
`ifdef SQRT2_HOST_TIMEOUT_EN
    checks++; if (k != int'(TO) + 1) begin failures++; $display("FAIL to_latency: got %0d want %0d", k, TO + 1); end
    checks++; if ({OUT_TIMEOUT, OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF, OUT_DATA} !== {4'b1100, FP16_QNAN}) begin
      failures++; $display("FAIL to_result: got %h want %h", {OUT_TIMEOUT, OUT_IS_NAN, OUT_IS_PINF, OUT_IS_NINF, OUT_DATA}, {4'b1100, FP16_QNAN});
    end
    OUT_READY = 1'b1; resp_stub = 1'b0; resp_lat = 1;
    @(posedge CLK); #1;
    send(16'h4400, ok);
    wait_valid(20, k);
    checks++; if (OUT_TIMEOUT !== 1'b0 || OUT_DATA !== 16'h4000) begin
      failures++; $display("FAIL to_clear: got t=%b d=%h want 0 4000", OUT_TIMEOUT, OUT_DATA);
    end
    @(posedge CLK); #1;
`else
    checks++; if (k != -1 || ENABLE !== 1'b1 || OUT_TIMEOUT !== 1'b0) begin
      failures++; $display("FAIL no_to_wait: got k=%0d en=%b t=%b want -1 1 0", k, ENABLE, OUT_TIMEOUT);
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; resp_stub = 1'b0;
`endif
  endtask

  task automatic test_reset_mid;
    bit ok; int k;
    resp_stub = 1'b1; OUT_READY = 1'b1;
    send(16'h3C00, ok);
    repeat (4) @(posedge CLK);
    #3; RESET = 1'b1; #1;
    checks++; if (ENABLE !== 1'b0 || io_data !== 16'hFFFF) begin
      failures++; $display("FAIL mid_rst_bus: got en=%b bus=%h want 0 ffff", ENABLE, io_data);
    end
    checks++; if (OUT_VALID !== 1'b0 || OUT_DATA !== 16'h0) begin
      failures++; $display("FAIL mid_rst_slot: got v=%b d=%h want 0 0000", OUT_VALID, OUT_DATA);
    end
    @(posedge CLK); #1;
    RESET = 1'b0; resp_stub = 1'b0; resp_lat = 2;
    @(negedge CLK);
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b want 1", IN_READY); end
    @(posedge CLK); #1;
    send(16'h3C00, ok);
    wait_valid(20, k);
    checks++; if (k != 2 + resp_lat || OUT_DATA !== 16'h3C00) begin
      failures++; $display("FAIL mid_rst_after: got k=%0d d=%h want %0d 3c00", k, OUT_DATA, 2 + resp_lat);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    IN_DATA = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1; RESET = 1'b0;
    test_reset();
    test_basic();
    test_specials();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
